dmem_resp: RTL and testbench

Multi-cycle data-memory responder serving load/store requests issued by the MEM pipeline stage. It accepts one request at a time over a valid/ready handshake, inserts a configurable number of wait cycles, performs byte/half/word access with byte-lane merge and load sign/zero extension, and returns a one-cycle response pulse. It replaces the single-cycle data array so that memory latency becomes visible to the pipeline's stall logic.

---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_lane.sv | 59 +++++
 rtl/dmem_resp.sv | 137 +++++++++++++
 tb/tb_dmem_resp.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for the dmem_resp multi-cycle data-memory responder.
// Holds the access-size codes, the controller state type and the wait-counter width.
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Wide enough for the largest legal wait count (15).
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_lane.sv
// dmem_lane: byte-lane store merge and load extract/extend for one 32-bit word.
// With DMEM_MISALIGN_TRAP_EN defined, misaligned half/word accesses raise misalign.
module dmem_lane
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] old_word,
    output logic [31:0] new_word,
    output logic [31:0] rdata,
    output logic        misalign
);

    logic [1:0]  offset;
    logic [3:0]  be;
    logic [31:0] wshift;
    logic [31:0] rshift;

    // Low address bits are always masked to the access size; trapping is decided by the flag only.
    always_comb begin
        offset   = 2'b00;
        be       = 4'b1111;
        new_word = old_word;
        case (size)
            SZ_B: begin
                offset = addr_lo;
                be     = 4'b0001 << addr_lo;
            end
            SZ_H: begin
                offset = {addr_lo[1], 1'b0};
                be     = 4'b0011 << {addr_lo[1], 1'b0};
            end
            default: ;
        endcase
        wshift = wdata << {offset, 3'b000};
        rshift = old_word >> {offset, 3'b000};
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                new_word[8*i +: 8] = wshift[8*i +: 8];
            end
        end
        case (size)
            SZ_B:    rdata = {{24{sext & rshift[7]}}, rshift[7:0]};
            SZ_H:    rdata = {{16{sext & rshift[15]}}, rshift[15:0]};
            default: rdata = old_word;
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign = (size == SZ_B) ? 1'b0 :
                      (size == SZ_H) ? addr_lo[0] :
                                       (addr_lo != 2'b00);
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: rtl/dmem_resp.sv
// dmem_resp: one-at-a-time load/store responder with WAIT_CYCLES of extra access latency.
// Define DMEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of masking them.
module dmem_resp
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sext,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_misalign,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             access;

    logic             r_we;
    logic [1:0]       r_size;
    logic             r_sext;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_pc;

    logic [31:0]      mem [DEPTH_WORDS];
    logic [AW-1:0]    idx;
    logic [31:0]      old_word;
    logic [31:0]      new_word;
    logic [31:0]      ld_data;
    logic             misalign;
    logic             unused_ok;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        access     = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_next = WAIT;
                    cnt_next   = CNT_W'(WAIT_CYCLES);
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    access     = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we    <= 1'b0;
            r_size  <= SZ_W;
            r_sext  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_pc    <= '0;
        end else if (state == IDLE && req_valid) begin
            r_we    <= req_we;
            r_size  <= req_size;
            r_sext  <= req_sext;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_pc    <= req_pc;
        end
    end

    // Upper address bits are dropped, so accesses wrap modulo the array size.
    assign idx      = r_addr[AW+1:2];
    assign old_word = mem[idx];

    dmem_lane u_lane (
        .size     (r_size),
        .sext     (r_sext),
        .addr_lo  (r_addr[1:0]),
        .wdata    (r_wdata),
        .old_word (old_word),
        .new_word (new_word),
        .rdata    (ld_data),
        .misalign (misalign)
    );

    // Memory has no reset; a reset in WAIT returns to IDLE, so the pending store never commits.
    always_ff @(posedge clk) begin
        if (access && r_we && !misalign) begin
            mem[idx] <= new_word;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_rdata    <= '0;
            rsp_misalign <= 1'b0;
        end else if (access) begin
            rsp_rdata    <= (r_we || misalign) ? '0 : ld_data;
            rsp_misalign <= misalign;
        end
    end

    assign rsp_valid = (state == RESP);
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign unused_ok = ^{r_pc, r_addr[31:AW+2]};

endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: directed self-checking bench for dmem_resp, with a byte-level memory model.
// Build with DMEM_MISALIGN_TRAP_EN defined to exercise the trapping variant.
module tb_dmem_resp;
    import dmem_pkg::*;

    localparam int WC      = 2;
    localparam int DEPTH   = 1024;
    localparam int TIMEOUT = 50;

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam logic MT = 1'b1;
`else
    localparam logic MT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_sext;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_misalign;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int          due;
        logic        we;
        logic [1:0]  size;
        logic        sext;
        logic [31:0] addr;
        logic [31:0] wdata;
    } op_t;

    op_t         pend[$];
    logic [31:0] model_mem [DEPTH];
    int          ncyc       = 0;
    int          busy_end   = -1;
    logic [31:0] hold_rdata = '0;
    logic        hold_mis   = 1'b0;
    logic        c_exp_valid;
    op_t         c_op;
    logic [31:0] c_rd;
    logic        c_mis;

    dmem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_sext     (req_sext),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_pc       (req_pc),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_misalign (rsp_misalign),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Model of one access: treat the word as four bytes and copy/extend the addressed ones.
    function automatic void model_access(input op_t op, output logic [31:0] rd, output logic mis);
        int         idx;
        int         width;
        int         base;
        logic [7:0] b [4];
        idx   = int'(op.addr[31:2] % 30'(DEPTH));
        width = (op.size == 2'b00) ? 1 : (op.size == 2'b01) ? 2 : 4;
        mis   = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        mis = (width == 2 && op.addr[0]) || (width == 4 && op.addr[1:0] != 2'b00);
`endif
        base = (width == 1) ? int'(op.addr[1:0]) : (width == 2) ? 2 * int'(op.addr[1]) : 0;
        for (int i = 0; i < 4; i++) b[i] = model_mem[idx][8*i +: 8];
        rd = '0;
        if (!mis) begin
            if (op.we) begin
                for (int i = 0; i < width; i++) b[base+i] = op.wdata[8*i +: 8];
                for (int i = 0; i < 4; i++) model_mem[idx][8*i +: 8] = b[i];
            end else begin
                for (int i = 0; i < width; i++) rd[8*i +: 8] = b[base+i];
                if (op.sext && width < 4 && rd[8*width-1]) begin
                    for (int i = width; i < 4; i++) rd[8*i +: 8] = 8'hFF;
                end
            end
        end
    endfunction

    // Every-cycle compare against the model; accepts are predicted from the model's own busy window.
    always @(negedge clk) begin
        ncyc++;
        if (!reset) begin
            pend.delete();
            busy_end   = -1;
            hold_rdata = '0;
            hold_mis   = 1'b0;
        end else begin
            c_exp_valid = (pend.size() > 0) && (pend[0].due == ncyc);
            check_output("rsp_valid", 32'(rsp_valid), 32'(c_exp_valid));
            check_output("req_ready", 32'(req_ready), 32'(ncyc > busy_end));
            check_output("busy", 32'(busy), 32'(ncyc <= busy_end));
            if (c_exp_valid) begin
                c_op = pend.pop_front();
                model_access(c_op, c_rd, c_mis);
                hold_rdata = c_rd;
                hold_mis   = c_mis;
            end
            check_output("rsp_rdata", rsp_rdata, hold_rdata);
            check_output("rsp_misalign", 32'(rsp_misalign), 32'(hold_mis));
            if (req_valid && ncyc > busy_end) begin
                c_op.due   = ncyc + WC + 2;
                c_op.we    = req_we;
                c_op.size  = req_size;
                c_op.sext  = req_sext;
                c_op.addr  = req_addr;
                c_op.wdata = req_wdata;
                pend.push_back(c_op);
                busy_end = c_op.due;
            end
        end
    end

    task automatic wait_ready();
        int waited = 0;
        while (!req_ready && waited < TIMEOUT) begin
            @(posedge clk);
            #1;
            waited++;
        end
    endtask

    task automatic apply_stimulus(input string name, input logic we, input logic [1:0] size,
                                  input logic sext, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] exp_rdata, input logic exp_mis);
        int lat;
        wait_ready();
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_sext  = sext;
        req_addr  = addr;
        req_wdata = wdata;
        req_pc    = 32'h0000_4000 + addr;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < TIMEOUT) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_output({name, " latency"}, 32'(lat), 32'(WC + 2));
        check_output({name, " rdata"}, rsp_rdata, exp_rdata);
        check_output({name, " misalign"}, 32'(rsp_misalign), 32'(exp_mis));
    endtask

    task automatic check_back_to_back();
        int ready_cnt = 0;
        int rsp_cnt   = 0;
        wait_ready();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = SZ_W;
        req_sext  = 1'b0;
        req_addr  = 32'h10;
        for (int k = 0; k < 4 * (WC + 3); k++) begin
            if (req_ready) ready_cnt++;
            if (rsp_valid) rsp_cnt++;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        check_output("b2b ready pulses", 32'(ready_cnt), 32'd4);
        check_output("b2b responses", 32'(rsp_cnt), 32'd4);
    endtask

    task automatic check_reset_in_wait();
        wait_ready();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = SZ_W;
        req_addr  = 32'h20;
        req_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_output("pre-reset busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_output("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("reset rsp_rdata", rsp_rdata, 32'h0);
        check_output("reset rsp_misalign", 32'(rsp_misalign), 32'd0);
        check_output("reset busy", 32'(busy), 32'd0);
        check_output("reset req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_size  = SZ_W;
        req_sext  = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_pc    = '0;
        #1;
        check_output("reset req_ready", 32'(req_ready), 32'd1);
        check_output("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("reset busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        $display("[TB] word, byte and half accesses");
        apply_stimulus("st w 0x10",   1'b1, SZ_W, 1'b0, 32'h10, 32'h1122_3344, 32'h0, 1'b0);
        apply_stimulus("ld w 0x10",   1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'h1122_3344, 1'b0);
        apply_stimulus("st w 0x20",   1'b1, SZ_W, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);
        apply_stimulus("st b 0x11",   1'b1, SZ_B, 1'b0, 32'h11, 32'h5555_55AA, 32'h0, 1'b0);
        apply_stimulus("ld bs 0x11",  1'b0, SZ_B, 1'b1, 32'h11, 32'h0, 32'hFFFF_FFAA, 1'b0);
        apply_stimulus("ld bu 0x11",  1'b0, SZ_B, 1'b0, 32'h11, 32'h0, 32'h0000_00AA, 1'b0);
        apply_stimulus("ld w 0x10 b", 1'b0, SZ_W, 1'b1, 32'h10, 32'h0, 32'h1122_AA44, 1'b0);
        apply_stimulus("st h 0x12",   1'b1, SZ_H, 1'b0, 32'h12, 32'h7777_8001, 32'h0, 1'b0);
        apply_stimulus("ld hs 0x12",  1'b0, SZ_H, 1'b1, 32'h12, 32'h0, 32'hFFFF_8001, 1'b0);
        apply_stimulus("ld hu 0x12",  1'b0, SZ_H, 1'b0, 32'h12, 32'h0, 32'h0000_8001, 1'b0);
        apply_stimulus("ld w 0x10 h", 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'h8001_AA44, 1'b0);

        $display("[TB] back-to-back requests and reset during WAIT");
        check_back_to_back();
        check_reset_in_wait();
        apply_stimulus("ld w 0x20 after reset", 1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);

        $display("[TB] misaligned accesses and address wrap");
        apply_stimulus("st w 0x20",  1'b1, SZ_W, 1'b0, 32'h20, 32'hCAFE_F00D, 32'h0, 1'b0);
        apply_stimulus("st h 0x21",  1'b1, SZ_H, 1'b0, 32'h21, 32'h0000_1234, 32'h0, MT);
        apply_stimulus("ld w 0x22",  1'b0, SZ_W, 1'b0, 32'h22, 32'h0,
                       MT ? 32'h0 : 32'hCAFE_1234, MT);
        apply_stimulus("ld w 0x20",  1'b0, SZ_W, 1'b0, 32'h20, 32'h0,
                       MT ? 32'hCAFE_F00D : 32'hCAFE_1234, 1'b0);
        apply_stimulus("ld b 0x23",  1'b0, SZ_B, 1'b0, 32'h23, 32'h0, 32'h0000_00CA, 1'b0);
        apply_stimulus("st w 0x1010", 1'b1, SZ_W, 1'b0, 32'h1010, 32'h5566_7788, 32'h0, 1'b0);
        apply_stimulus("ld sz3 0x10", 1'b0, 2'b11, 1'b1, 32'h10, 32'h0, 32'h5566_7788, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
